act_buf_mport: RTL
==================

# act_buf_mport

Parametrised multi-port activation buffer: `numWr` independent element-granular write ports with per-element masks, and one wide read port with selectable element order and 1- or 2-cycle latency. It adds a hardware clear engine that zeroes the array at reset or on request. It sits between the activation loaders/array output writeback and the compute array input, replacing the single-cycle two-write-port standin RAM.

## Interface
- `addrWidth`, 10: element address width; `depth` = 2**addrWidth.
- `dataSize`, 8: bits per element.
- `numWr`, 2: number of write ports, ≥1.
- `wrElems`, 4: elements per write beat; power of two, ≤ depth.
- `rdElems`, 32: elements per read beat; power of two, ≤ depth.
- `rdLatency`, 1: read latency in cycles, 1 or 2.
- `rdReverse`, 1: 1 = element 0 of `data_o` is the highest-addressed element read; 0 = natural order.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en_i` in numWr: per-port write enable.
- `wr_addr_i` in numWr*addrWidth: base element address, port p at bits [p*addrWidth +: addrWidth].
- `wr_data_i` in numWr*wrElems*dataSize: port p, element k at [(p*wrElems+k)*dataSize +: dataSize].
- `wr_mask_i` in numWr*wrElems: per-element write enable, port p element k at bit p*wrElems+k.
- `rd_en_i` in 1: read request.
- `rd_addr_i` in addrWidth: base element address of read.
- `clr_i` in 1: single-cycle clear request.
- `data_o` out rdElems*dataSize: read data.
- `rd_valid_o` out 1: `data_o` holds a requested read.
- `busy_o` out 1: clear engine active.

## Operation
- Addressing is per element; all address arithmetic is modulo depth (addrWidth-bit wrap, carry discarded).
- Write: port p element k written to mem[(wr_addr + k) mod depth] iff `wr_en_i[p]` & `wr_mask_i[p*wrElems+k]` & state IDLE.
- Collision: two ports hitting the same element in one cycle → highest port index wins; other elements of both beats still written.
- Read: element i of the read beat = mem[(rd_addr + j) mod depth], j = rdElems-1-i if rdReverse else i.
- Read-during-write to the same element: read-first, returns contents before that edge's write.
- `rd_en_i` low → `data_o` = 0 and `rd_valid_o` = 0 in the corresponding output cycle.
- FSM states: CLEAR, IDLE.
  - CLEAR: pointer ptr starts at 0; each cycle zeroes wrElems elements [ptr, ptr+wrElems) and ptr += wrElems. After the beat at ptr = depth-wrElems, go to IDLE.
  - IDLE → CLEAR on `clr_i`=1, with ptr reset to 0.
  - `clr_i` while in CLEAR is ignored and does not restart the sweep.
- In CLEAR, writes are dropped and reads are served from current (partially cleared) contents.
- `busy_o` = (state == CLEAR).

## Timing
- Reset (`rst` high at an edge): state ← CLEAR, ptr ← 0, `data_o` ← 0, `rd_valid_o` ← 0, all read pipeline stages ← 0. `busy_o` = 1 while in reset and after it.
- Reset asserted mid-sweep or mid-read restarts the sweep from 0 and flushes the read pipeline.
- Clear duration is depth/wrElems cycles (256 at defaults) counted from the first non-reset edge. `busy_o` falls the cycle after the last beat, and writes are accepted from that cycle.
- `clr_i` sampled at edge t in IDLE: `busy_o` = 1 from t+1; the first zero beat is written at edge t+1.
- Read latency:
  - `rdLatency`=1: request at edge t → `data_o`/`rd_valid_o` valid after edge t.
  - `rdLatency`=2: valid after edge t+1.
  - Fully pipelined, one read accepted per cycle.
- Write latency: data written at edge t is visible to a read sampled at edge t+1.

## Test plan
- Reset then idle: hold `rst` 3 cycles, release → `busy_o`=1 for exactly 256 cycles, then 0; `data_o`=0 and `rd_valid_o`=0 throughout.
- Port 0 writes {0x04,0x03,0x02,0x01} (k=3..0) at addr 0 with mask 0xF; `rdElems`=4 read at 0 → `data_o`=0x01020304 with rdReverse=1, 0x04030201 with rdReverse=0; valid 1 or 2 cycles later per `rdLatency`.
- Collision: port 0 and port 1 both write addr 8 in the same cycle, data 0xAA.. and 0x55.., mask 0xF → readback all 0x55. Mask 0x5 on port 1 → elements 8,10 = 0x55 and 9,11 = 0xAA.
- Wrap: port 0 write at addr 1022, data {0x44,0x33,0x22,0x11} → mem[1022]=0x11, mem[1023]=0x22, mem[0]=0x33, mem[1]=0x44; read at 1022 returns the same four elements.
- Read-during-write: write 0x77.. to addr 16 while reading addr 16 in the same cycle → read returns old value; read the next cycle returns 0x77.
- Clear mid-operation: fill memory, pulse `clr_i`, write on port 0 during busy, pulse `clr_i` again at cycle 100 → write dropped, sweep not restarted, `busy_o` high exactly 256 cycles, all reads afterwards 0. Assert `rst` at cycle 50 of a second sweep → sweep restarts, 256 further busy cycles.

Source files
------------

// File: rtl/act_buf_mport_if.sv
// act_buf_mport_if: bundle of write ports, read port, clear request and
// status outputs of the multi-port activation buffer. The master side
// (loaders / writeback / compute input) drives requests, the slave side is
// the buffer itself.
interface act_buf_mport_if #(
  parameter int addrWidth = 10,
  parameter int dataSize  = 8,
  parameter int numWr     = 2,
  parameter int wrElems   = 4,
  parameter int rdElems   = 32
) ();

  // Write side: numWr independent element-granular ports
  logic [numWr-1:0]                  wr_en_i;
  logic [numWr*addrWidth-1:0]        wr_addr_i;
  logic [numWr*wrElems*dataSize-1:0] wr_data_i;
  logic [numWr*wrElems-1:0]          wr_mask_i;

  // Read side: one wide port
  logic                              rd_en_i;
  logic [addrWidth-1:0]              rd_addr_i;

  // Clear request and status
  logic                              clr_i;
  logic [rdElems*dataSize-1:0]       data_o;
  logic                              rd_valid_o;
  logic                              busy_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, wr_mask_i,
    output rd_en_i, rd_addr_i, clr_i,
    input  data_o, rd_valid_o, busy_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, wr_mask_i,
    input  rd_en_i, rd_addr_i, clr_i,
    output data_o, rd_valid_o, busy_o
  );

endinterface

// File: rtl/act_buf_mport.sv
// act_buf_mport: multi-port activation buffer.
//  - numWr element-granular write ports with per-element masks; when ports
//    collide on an element the highest port index wins.
//  - one wide read port, read-first, optional element reversal, 1 or 2
//    cycle latency, fully pipelined; idle cycles present zero data.
//  - a clear engine sweeps wrElems zero elements per cycle after reset or on
//    request; writes are dropped while it runs, reads still see the array.
// The interface instance must be built with the same geometry parameters.
module act_buf_mport #(
  parameter int addrWidth = 10,
  parameter int dataSize  = 8,
  parameter int numWr     = 2,
  parameter int wrElems   = 4,
  parameter int rdElems   = 32,
  parameter int rdLatency = 1,
  parameter int rdReverse = 1
) (
  input  logic             clk,
  input  logic             rst,
  act_buf_mport_if.slave   bus
);

  localparam int depth = 1 << addrWidth;
  localparam int RD_W  = rdElems * dataSize;

  // Clear engine states; CLEAR is the reset state so the array is always
  // swept before first use.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Pointer of the final clear beat and the per-beat pointer increment
  localparam logic [addrWidth-1:0] LAST_PTR = addrWidth'(depth - wrElems);
  localparam logic [addrWidth-1:0] PTR_STEP = addrWidth'(wrElems);

  // Storage and clear engine state
  logic [dataSize-1:0]  r_mem [depth];
  logic [0:0]           r_state;
  logic [addrWidth-1:0] r_ptr;

  // Per-element write lanes (port x element)
  logic [addrWidth-1:0] w_wr_addr [numWr][wrElems];
  logic                 w_wr_en   [numWr][wrElems];
  logic [dataSize-1:0]  w_wr_data [numWr][wrElems];

  // Clear lanes and read lanes
  logic [addrWidth-1:0] w_clr_addr [wrElems];
  logic [addrWidth-1:0] w_rd_addr  [rdElems];
  logic [RD_W-1:0]      w_rd_data;

  // Read pipeline; the last stage drives the outputs
  logic [RD_W-1:0]      r_rd_data  [rdLatency];
  logic                 r_rd_valid [rdLatency];

  // Split each write beat into element lanes with modulo-depth addresses.
  always_comb begin
    for (int p = 0; p < numWr; p++) begin
      for (int k = 0; k < wrElems; k++) begin
        w_wr_addr[p][k] = bus.wr_addr_i[p*addrWidth +: addrWidth] + addrWidth'(k);
        w_wr_en[p][k]   = bus.wr_en_i[p] & bus.wr_mask_i[p*wrElems + k];
        w_wr_data[p][k] = bus.wr_data_i[(p*wrElems + k)*dataSize +: dataSize];
      end
    end
  end

  // Element addresses zeroed by the current clear beat.
  always_comb begin
    for (int k = 0; k < wrElems; k++) begin
      w_clr_addr[k] = r_ptr + addrWidth'(k);
    end
  end

  // Gather the read beat from the array, applying the element order.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < rdElems; i++) begin
      if (rdReverse != 0) begin
        w_rd_addr[i] = bus.rd_addr_i + addrWidth'(rdElems - 1 - i);
      end else begin
        w_rd_addr[i] = bus.rd_addr_i + addrWidth'(i);
      end
      w_rd_data[i*dataSize +: dataSize] = r_mem[w_rd_addr[i]];
    end
  end

  // Clear engine: sweep from 0 after reset or a clear request in IDLE;
  // requests during a sweep are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == LAST_PTR) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr   <= r_ptr + PTR_STEP;
          end
        end
        ST_IDLE: begin
          if (bus.clr_i) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end else begin
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Array update: clear beat while sweeping, else masked port writes.
  // Ports are visited in ascending order so the highest index lands last
  // on a shared element.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        for (int k = 0; k < wrElems; k++) begin
          r_mem[w_clr_addr[k]] <= '0;
        end
      end else begin
        for (int p = 0; p < numWr; p++) begin
          for (int k = 0; k < wrElems; k++) begin
            if (w_wr_en[p][k]) begin
              r_mem[w_wr_addr[p][k]] <= w_wr_data[p][k];
            end
          end
        end
      end
    end
  end

  // Read pipeline: capture (read-first) on request, zero when idle,
  // then shift through any extra latency stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < rdLatency; s++) begin
        r_rd_data[s]  <= '0;
        r_rd_valid[s] <= 1'b0;
      end
    end else begin
      r_rd_valid[0] <= bus.rd_en_i;
      r_rd_data[0]  <= bus.rd_en_i ? w_rd_data : '0;
      for (int s = 1; s < rdLatency; s++) begin
        r_rd_data[s]  <= r_rd_data[s-1];
        r_rd_valid[s] <= r_rd_valid[s-1];
      end
    end
  end

  assign bus.data_o     = r_rd_data[rdLatency-1];
  assign bus.rd_valid_o = r_rd_valid[rdLatency-1];
  assign bus.busy_o     = (r_state == ST_CLEAR);

endmodule
